// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer sharing one 256x16 data memory port between two masters.
// Latency: request sampled at edge N -> memory driven in cycle N+1 -> ack + read data in cycle N+2.
// Backpressure: req is held until ack; one transaction per 3 cycles; the losing master waits at most one foreign transaction.
// Optional: define DMEM_ARB_LOCK_EN to add m0_lock (master 0 bus lock for atomic read-modify-write).
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic          m0_lock,
`endif
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]    r_state;
    logic          r_last;       // master served by the most recent completed transaction
    logic          r_grant;      // owner of the current / last transaction
    logic          r_cmd_we;
    logic [AW-1:0] r_cmd_addr;
    logic [DW-1:0] r_cmd_wdata;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_m1_elig;
    logic          w_any;
    logic          w_win;
    logic          w_access;

`ifdef DMEM_ARB_LOCK_EN
    logic          r_locked;

    // While master 0 holds the lock, master 1 is invisible to arbitration.
    assign w_m1_elig = m1_req & ~(r_locked & m0_lock);

    // Lock is armed by master 0's RESP with m0_lock high, released when m0_lock is seen low in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (r_state == S_IDLE && r_locked && !m0_lock) begin
            r_locked <= 1'b0;
        end else if (r_state == S_RESP && !r_grant) begin
            r_locked <= m0_lock;
        end
    end
`else
    assign w_m1_elig = m1_req;
`endif

    // Single requester wins outright; under contention the master not served last wins.
    assign w_any = m0_req | w_m1_elig;
    assign w_win = (m0_req & w_m1_elig) ? ~r_last : w_m1_elig;

    // Sequencer: IDLE latches the winner's command, ACCESS drives memory, RESP acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_win;
                        r_cmd_we    <= w_win ? m1_we    : m0_we;
                        r_cmd_addr  <= w_win ? m1_addr  : m0_addr;
                        r_cmd_wdata <= w_win ? m1_wdata : m0_wdata;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_last  <= r_grant;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data is captured at the closing edge of ACCESS into the winner's register only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (r_state == S_ACCESS && !r_cmd_we) begin
            if (r_grant) begin
                r_m1_rdata <= mem_rdata;
            end else begin
                r_m0_rdata <= mem_rdata;
            end
        end
    end

    // Memory strobes are decoded from the registered state, so reset removes them immediately.
    assign w_access  = (r_state == S_ACCESS);
    assign mem_cs    = w_access;
    assign mem_we    = w_access &  r_cmd_we;
    assign mem_oe    = w_access & ~r_cmd_we;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;

    assign busy      = (r_state != S_IDLE);
    assign grant_id  = r_grant;
    assign m0_ack    = (r_state == S_RESP) & ~r_grant;
    assign m1_ack    = (r_state == S_RESP) &  r_grant;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule
